minimips_instr_encoder: RTL
===========================

Name: minimips_instr_encoder

Overview:
- Streaming instruction encoder; the inverse of the control/ALU decode path.
- Accepts symbolic instructions (operation class, register fields, immediate) and emits 32-bit MiniMIPS machine words.
- Each emitted word is tagged with a sequential instruction-memory word address.
- Used by the instruction-memory loader and the self-checking benches to build programs for the 5-stage pipeline.

Parameters:
- ADDR_W, 8, width of the emitted word address; wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, address loaded at reset and on clear.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: empties the output stage and reloads address and counter.
- in_valid  input  1  input instruction valid.
- in_ready  output  1  encoder can accept an input this cycle.
- in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 J, 9-15 illegal.
- in_rs  input  5  source register.
- in_rt  input  5  target register.
- in_rd  input  5  destination register (R-type only).
- in_imm  input  26  signed immediate for LW/SW/BEQ; jump target for J.
- out_valid  output  1  out_instr/out_addr valid.
- out_ready  input  1  downstream accepts.
- out_instr  output  32  encoded machine word.
- out_addr  output  ADDR_W  word address of out_instr.
- err_illegal  output  1  one-cycle pulse when an input is rejected.
- illegal_count  output  CNT_W  saturating count of rejected inputs.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_illegal=0, illegal_count=0, state EMIT.
- Input handshake is in_valid && in_ready. in_ready = (state==EMIT) && (!out_valid || out_ready); no combinational dependency on in_valid.
- Latency: 1 cycle. The registered output stage sustains full throughput, one word per cycle.
- Output holds out_instr and out_addr stable while out_valid && !out_ready.
- out_addr increments by 1 (mod 2^ADDR_W) after every output handshake. The word emitted after address 2^ADDR_W-1 carries address 0.
- R-type encoding: {6'b000000, rs, rt, rd, 5'b0, funct}.
  - funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- LW: {100011, rs, rt, imm[15:0]}.
- SW: {101011, rs, rt, imm[15:0]}.
- BEQ: {000100, rs, rt, imm[15:0]}.
- J: {000010, imm[25:0]}.
- Range check for LW/SW/BEQ: imm[25:15] must be all-0 or all-1 (valid 16-bit sign extension); otherwise the input is illegal.
- Illegal input (op 9-15 or range failure):
  - Consumed by the handshake; no word emitted; address not advanced.
  - err_illegal=1 on the following cycle.
  - illegal_count increments, saturating at 2^CNT_W-1.
- clear=1:
  - Next cycle: out_valid=0, out_addr=BASE_ADDR, illegal_count=0, state EMIT.
  - Any same-cycle input handshake or output handshake is discarded; clear has priority.
  - in_ready=0 while clear=1.
- Illegal input while the output is stalled: the input is still accepted only if in_ready=1. No overtaking of the pending word.

Optional Feature:
- Macro MINIMIPS_ENC_NOP_PAD_EN.
- Defined: adds a PAD state. When a BEQ or J word completes its output handshake, the next cycle presents out_instr=32'h00000000 (NOP) at the next address with out_valid=1.
  - in_ready=0 while in PAD.
  - The NOP handshake returns the state to EMIT.
  - clear in PAD drops the NOP and returns to EMIT.
- Undefined: no PAD state; BEQ/J are followed directly by the next input.

Test Plan:
- Reset, then ADD rs=1 rt=2 rd=3 -> out_instr=0x00221820 at out_addr=0x00, one cycle after the input handshake.
- Back-to-back LW rs=1 rt=2 imm=4, then SW rs=0 rt=2 imm=8, with out_ready=1 -> 0x8C220004 at addr 0, then 0xAC020008 at addr 1; in_ready stays 1.
- BEQ rs=1 rt=2 imm=0x3FFFFFF, then J imm=0x10 -> 0x1022FFFF, then 0x08000010.
  - With MINIMIPS_ENC_NOP_PAD_EN: a NOP 0x00000000 follows each, at addrs 1 and 3.
- in_op=15, then LW imm=0x0008000 -> no output for either; err_illegal pulses twice; illegal_count=2; out_addr unchanged.
- Hold out_ready=0 for 3 cycles with a pending word -> out_instr stable, in_ready=0. Set out_ready=1 -> handshake completes and the address increments.
- Set BASE_ADDR=0xFE, emit 3 words -> addresses 0xFE, 0xFF, 0x00. Assert clear with a pending word -> out_valid=0 next cycle, out_addr=0xFE.

Source files
------------

// File: rtl/minimips_instr_encoder.sv
// ============================================================================
// Module   : minimips_instr_encoder
// Brief    : Streaming MiniMIPS encoder; symbolic instructions in, 32-bit
//            words tagged with a sequential word address out.
//            Optional NOP padding after BEQ/J: MINIMIPS_ENC_NOP_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minimips_instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam logic [ADDR_W-1:0] c_base_addr = BASE_ADDR[ADDR_W-1:0];
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_slt = 4'd4;
    localparam logic [3:0] c_op_lw  = 4'd5;
    localparam logic [3:0] c_op_sw  = 4'd6;
    localparam logic [3:0] c_op_beq = 4'd7;
    localparam logic [3:0] c_op_j   = 4'd8;

    localparam logic [5:0] c_opc_rtype = 6'b000000;
    localparam logic [5:0] c_opc_lw    = 6'b100011;
    localparam logic [5:0] c_opc_sw    = 6'b101011;
    localparam logic [5:0] c_opc_beq   = 6'b000100;
    localparam logic [5:0] c_opc_j     = 6'b000010;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    typedef enum logic [0:0] {
        ST_EMIT = 1'b0,
        ST_PAD  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_out_valid;
    logic [31:0]        r_out_instr;
    logic [ADDR_W-1:0]  r_out_addr;
    logic               r_err_illegal;
    logic [CNT_W-1:0]   r_illegal_count;
    logic               r_pad_pending;

    logic               w_imm_ok;
    logic               w_legal;
    logic [31:0]        w_word;
    logic               w_pad_arm;
    logic               w_in_fire;
    logic               w_out_fire;

    // Branch and jump words arm the NOP slot only when padding is built in.
`ifdef MINIMIPS_ENC_NOP_PAD_EN
    assign w_pad_arm = (in_op == c_op_beq) || (in_op == c_op_j);
`else
    assign w_pad_arm = 1'b0;
`endif

    // A word that will be followed by a NOP cannot share its handshake cycle
    // with a new input, otherwise the NOP slot would be overwritten.
    assign in_ready   = !clear && (r_state == ST_EMIT)
                        && (!r_out_valid || out_ready)
                        && !(r_out_valid && r_pad_pending);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    assign out_valid     = r_out_valid;
    assign out_instr     = r_out_instr;
    assign out_addr      = r_out_addr;
    assign err_illegal   = r_err_illegal;
    assign illegal_count = r_illegal_count;

    // 16-bit offsets must be a faithful sign extension of the 26-bit field.
    assign w_imm_ok = (in_imm[25:15] == '0) || (in_imm[25:15] == '1);

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (in_op)
            c_op_add: w_word = {c_opc_rtype, in_rs, in_rt, in_rd, 5'b0, c_fn_add};
            c_op_sub: w_word = {c_opc_rtype, in_rs, in_rt, in_rd, 5'b0, c_fn_sub};
            c_op_and: w_word = {c_opc_rtype, in_rs, in_rt, in_rd, 5'b0, c_fn_and};
            c_op_or:  w_word = {c_opc_rtype, in_rs, in_rt, in_rd, 5'b0, c_fn_or};
            c_op_slt: w_word = {c_opc_rtype, in_rs, in_rt, in_rd, 5'b0, c_fn_slt};
            c_op_lw: begin
                w_word  = {c_opc_lw, in_rs, in_rt, in_imm[15:0]};
                w_legal = w_imm_ok;
            end
            c_op_sw: begin
                w_word  = {c_opc_sw, in_rs, in_rt, in_imm[15:0]};
                w_legal = w_imm_ok;
            end
            c_op_beq: begin
                w_word  = {c_opc_beq, in_rs, in_rt, in_imm[15:0]};
                w_legal = w_imm_ok;
            end
            c_op_j:   w_word = {c_opc_j, in_imm};
            default:  w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_EMIT;
            r_out_valid     <= 1'b0;
            r_out_instr     <= '0;
            r_out_addr      <= c_base_addr;
            r_err_illegal   <= 1'b0;
            r_illegal_count <= '0;
            r_pad_pending   <= 1'b0;
        end else if (clear) begin
            r_state         <= ST_EMIT;
            r_out_valid     <= 1'b0;
            r_out_addr      <= c_base_addr;
            r_err_illegal   <= 1'b0;
            r_illegal_count <= '0;
            r_pad_pending   <= 1'b0;
        end else begin
            r_err_illegal <= w_in_fire && !w_legal;
            if (w_in_fire && !w_legal && (r_illegal_count != c_cnt_max)) begin
                r_illegal_count <= r_illegal_count + 1'b1;
            end
            // The address always names the word currently (or next) on the output.
            if (w_out_fire) begin
                r_out_addr <= r_out_addr + 1'b1;
            end
            case (r_state)
                ST_EMIT: begin
                    if (w_in_fire && w_legal) begin
                        r_out_valid   <= 1'b1;
                        r_out_instr   <= w_word;
                        r_pad_pending <= w_pad_arm;
                    end else if (w_out_fire) begin
                        if (r_pad_pending) begin
                            r_out_valid   <= 1'b1;
                            r_out_instr   <= '0;
                            r_pad_pending <= 1'b0;
                            r_state       <= ST_PAD;
                        end else begin
                            r_out_valid   <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMIT;
                    end
                end
                default: r_state <= ST_EMIT;
            endcase
        end
    end

endmodule

`default_nettype wire
